// File: rtl/key_lock_pkg.sv
// key_lock_pkg: shared state encoding, default secret/flag and counter width helper
package key_lock_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, GRANT, LOCKED} state_t;

    localparam logic [15:0] DEF_SECRET = 16'hD68D;
    localparam logic [15:0] DEF_FLAG   = 16'hB56B;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_lock_checker_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus rising-edge detector for a raw push-button
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic press
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign press = s2 & ~s3;

endmodule

// File: rtl/key_lock_checker.sv
// key_lock_checker: button-triggered key compare with timed flag window and lockout.
// Define KEY_LOCK_ILA_EN to attach the ila_1 debug core.
module key_lock_checker
    import key_lock_pkg::*;
#(
    parameter int                KEY_W       = 16,
    parameter logic [KEY_W-1:0]  SECRET      = KEY_W'(DEF_SECRET),
    parameter int                FLAG_W      = 16,
    parameter logic [FLAG_W-1:0] FLAG        = FLAG_W'(DEF_FLAG),
    parameter int                HOLD_CYCLES = 4,
    parameter int                MAX_TRIES   = 3,
    parameter int                LOCK_CYCLES = 1024,
    localparam int               TW          = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_switch,
    input  logic              show_button,
    output logic [FLAG_W-1:0] flag,
    output logic              granted,
    output logic              denied,
    output logic              locked,
    output logic [TW-1:0]     tries_left
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int LW = cnt_w(LOCK_CYCLES);

    state_t            state, state_n;
    logic              press;
    logic [KEY_W-1:0]  ks1, ks2, key_q, key_n;
    logic [HW-1:0]     hold, hold_n;
    logic [LW-1:0]     lock, lock_n;
    logic [TW-1:0]     fail, fail_n;
    logic [FLAG_W-1:0] flag_n;
    logic              granted_n, denied_n, locked_n;

    btn_sync_edge u_btn (
        .clk    (clk),
        .rst    (rst),
        .btn_in (show_button),
        .press  (press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ks1        <= '0;
            ks2        <= '0;
            key_q      <= '0;
            hold       <= '0;
            lock       <= '0;
            fail       <= '0;
            flag       <= '0;
            granted    <= 1'b0;
            denied     <= 1'b0;
            locked     <= 1'b0;
            tries_left <= TW'(MAX_TRIES);
        end else begin
            state      <= state_n;
            ks1        <= key_switch;
            ks2        <= ks1;
            key_q      <= key_n;
            hold       <= hold_n;
            lock       <= lock_n;
            fail       <= fail_n;
            flag       <= flag_n;
            granted    <= granted_n;
            denied     <= denied_n;
            locked     <= locked_n;
            tries_left <= TW'(MAX_TRIES) - fail_n;
        end
    end

    // Outputs are computed here as next values so they register with the state.
    always_comb begin
        state_n   = state;
        key_n     = key_q;
        hold_n    = hold;
        lock_n    = lock;
        fail_n    = fail;
        flag_n    = flag;
        granted_n = granted;
        denied_n  = 1'b0;
        locked_n  = locked;
        case (state)
            IDLE: begin
                if (press) begin
                    key_n   = ks2;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (key_q == SECRET) begin
                    state_n   = GRANT;
                    flag_n    = FLAG;
                    granted_n = 1'b1;
                    hold_n    = HW'(HOLD_CYCLES - 1);
                    fail_n    = '0;
                end else begin
                    denied_n = 1'b1;
                    fail_n   = fail + 1'b1;
                    state_n  = (fail_n == TW'(MAX_TRIES)) ? LOCKED : IDLE;
                    locked_n = (fail_n == TW'(MAX_TRIES));
                    lock_n   = LW'(LOCK_CYCLES - 1);
                end
            end
            GRANT: begin
                state_n   = (hold == '0) ? IDLE : GRANT;
                flag_n    = (hold == '0) ? '0 : flag;
                granted_n = (hold != '0);
                hold_n    = (hold == '0) ? hold : hold - 1'b1;
            end
            LOCKED: begin
                state_n  = (lock == '0) ? IDLE : LOCKED;
                locked_n = (lock != '0);
                fail_n   = (lock == '0) ? '0 : fail;
                lock_n   = (lock == '0) ? lock : lock - 1'b1;
            end
        endcase
    end

`ifdef KEY_LOCK_ILA_EN
    ila_1 u_ila (
        .clk    (clk),
        .probe0 (~(key_q ^ SECRET)),
        .probe1 (granted),
        .probe2 (flag),
        .probe3 (state)
    );
`else
`endif

endmodule

// File: tb/tb_key_lock_checker.sv
// tb_key_lock_checker: table-driven attempt vectors plus hand sequences for hold, reset and lockout
module tb_key_lock_checker;

    localparam logic [15:0] KEY_OK  = 16'hD68D;
    localparam logic [15:0] FLAG_V  = 16'hB56B;
    localparam logic [16:0] G_TRACE = 17'h000F0;
    localparam logic [16:0] D_TRACE = 17'h00010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_switch = '0;
    logic        show_button = 1'b0;
    logic [15:0] flag;
    logic        granted, denied, locked;
    logic [1:0]  tries_left;

    int nvec = 0;
    int nfail = 0;
    int lock_cycles = 0;

    key_lock_checker dut (
        .clk         (clk),
        .rst         (rst),
        .key_switch  (key_switch),
        .show_button (show_button),
        .flag        (flag),
        .granted     (granted),
        .denied      (denied),
        .locked      (locked),
        .tries_left  (tries_left)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (locked) lock_cycles++;

    typedef struct {
        logic [15:0] key;
        bit          grant;
        bit          deny;
        logic [1:0]  tries;
        bit          lck;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One press at sample 0; samples 1..16 are the negedges after it.
    task automatic attempt(input logic [15:0] key, input int pulse2,
                           output logic [16:0] g, output logic [16:0] d, output bit flag_ok);
        key_switch = key;
        repeat (3) @(negedge clk);
        show_button = 1'b1;
        g = '0;
        d = '0;
        flag_ok = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            g[i] = granted;
            d[i] = denied;
            if (flag !== (granted ? FLAG_V : 16'h0)) flag_ok = 1'b0;
            if (i == 1) show_button = 1'b0;
            if (pulse2 != 0 && i == pulse2) show_button = 1'b1;
            if (pulse2 != 0 && i == pulse2 + 1) show_button = 1'b0;
        end
    endtask

    task automatic wait_unlock();
        int n;
        n = 0;
        while (locked && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("unlock_timeout", 32'(locked), 32'd0);
        chk("lock_len", 32'(lock_cycles), 32'd1024);
        chk("tries_after_unlock", 32'(tries_left), 32'd3);
    endtask

    initial begin
        logic [16:0] g, d;
        bit          fok;
        int          gcnt, rises, dcnt;
        logic        gprev;
        bit          ok;

        vecs[0]  = '{KEY_OK,   1, 0, 2'd3, 0};
        vecs[1]  = '{16'h0000, 0, 1, 2'd2, 0};
        vecs[2]  = '{16'h0000, 0, 1, 2'd1, 0};
        vecs[3]  = '{16'h0000, 0, 1, 2'd0, 1};
        vecs[4]  = '{KEY_OK,   0, 0, 2'd0, 1};
        vecs[5]  = '{16'h1234, 0, 1, 2'd2, 0};
        vecs[6]  = '{16'h0000, 0, 1, 2'd1, 0};
        vecs[7]  = '{KEY_OK,   1, 0, 2'd3, 0};
        vecs[8]  = '{16'hFFFF, 0, 1, 2'd2, 0};
        vecs[9]  = '{16'hD68C, 0, 1, 2'd1, 0};
        vecs[10] = '{KEY_OK,   1, 0, 2'd3, 0};

        repeat (3) @(negedge clk);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_granted", 32'(granted), 32'd0);
        chk("rst_tries", 32'(tries_left), 32'd3);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_denied", 32'(denied), 32'd0);
        chk("idle_locked", 32'(locked), 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (i == 5) wait_unlock();
            attempt(vecs[i].key, 0, g, d, fok);
            chk($sformatf("v%0d_granted_trace", i), 32'(g), vecs[i].grant ? 32'(G_TRACE) : 32'd0);
            chk($sformatf("v%0d_denied_trace", i), 32'(d), vecs[i].deny ? 32'(D_TRACE) : 32'd0);
            chk($sformatf("v%0d_flag", i), 32'(fok), 32'd1);
            chk($sformatf("v%0d_tries", i), 32'(tries_left), 32'(vecs[i].tries));
            chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vecs[i].lck));
        end

        // Second press during GRANT is discarded.
        attempt(KEY_OK, 5, g, d, fok);
        chk("press2_granted_trace", 32'(g), 32'(G_TRACE));
        chk("press2_denied_trace", 32'(d), 32'd0);
        chk("press2_flag", 32'(fok), 32'd1);

        // Button held for 200 cycles gives one window.
        key_switch = KEY_OK;
        repeat (3) @(negedge clk);
        show_button = 1'b1;
        gcnt = 0;
        rises = 0;
        dcnt = 0;
        gprev = 1'b0;
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            if (i == 199) show_button = 1'b0;
            gcnt += int'(granted);
            dcnt += int'(denied);
            if (granted && !gprev) rises++;
            gprev = granted;
        end
        chk("held_windows", 32'(rises), 32'd1);
        chk("held_grant_cycles", 32'(gcnt), 32'd4);
        chk("held_denied", 32'(dcnt), 32'd0);

        // Reset in the second GRANT cycle.
        key_switch = KEY_OK;
        repeat (3) @(negedge clk);
        show_button = 1'b1;
        @(negedge clk);
        show_button = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_granted", 32'(granted), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_flag", 32'(flag), 32'd0);
        chk("mid_rst_granted", 32'(granted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", 32'(dut.state), 32'(key_lock_pkg::IDLE));
        chk("post_rst_tries", 32'(tries_left), 32'd3);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (granted || flag != 16'h0) ok = 1'b0;
        end
        chk("post_rst_quiet", 32'(ok), 32'd1);
        attempt(KEY_OK, 0, g, d, fok);
        chk("post_rst_grant_trace", 32'(g), 32'(G_TRACE));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
